// File: rtl/inv_permutation_stream_pkg.sv
// Shared constants, FSM state encoding and the inverse pi-step index map
// for the 5x5 bit-matrix permutation decoder.
package perm_pkg;

    localparam int LINE_W  = 25;
    localparam int MAT_DIM = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PERMUTE = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Source bit in the encoded line for decoded bit u + 5*v.
    // 2 is the inverse of 3 mod 5, which undoes the forward x+3y shear.
    function automatic int inv_pi_idx(input int u, input int v);
        return v + MAT_DIM * (((32'sd2 * u) + (32'sd3 * v)) % MAT_DIM);
    endfunction

endpackage

// File: rtl/inv_permutation_stream_if.sv
// Input and output valid/ready line streams of the permutation decoder.
interface inv_permutation_stream_if;
    import perm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [LINE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LINE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/inv_permutation_stream_inv_pi_25.sv
// Combinational 25-bit rewiring that undoes the forward pi-step permutation.
module inv_pi_25
    import perm_pkg::*;
(
    input  logic [LINE_W-1:0] enc,
    output logic [LINE_W-1:0] dec
);

    for (genvar v = 0; v < MAT_DIM; v++) begin : g_row
        for (genvar u = 0; u < MAT_DIM; u++) begin : g_col
            assign dec[u + MAT_DIM * v] = enc[inv_pi_idx(u, v)];
        end
    end

endmodule

// File: rtl/inv_permutation_stream.sv
// Frame-based streaming decoder for the 5x5 pi-step permutation, one line in flight.
// Optional INV_PERM_BYPASS_EN adds a per-frame bypass input that passes lines through unaltered.
module inv_permutation_stream
    import perm_pkg::*;
#(
    parameter int LINES = 64,
    parameter int CNT_W = $clog2(LINES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
`ifdef INV_PERM_BYPASS_EN
    input  logic                     bypass,
`endif
    inv_permutation_stream_if.slave  bus,
    output logic                     busy,
    output logic                     done
);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [LINE_W-1:0] data_r;
    logic [LINE_W-1:0] perm_s;
    logic [LINE_W-1:0] next_data_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;

    inv_pi_25 u_inv_pi (
        .enc (data_r),
        .dec (perm_s)
    );

`ifdef INV_PERM_BYPASS_EN
    logic bypass_r;

    // Frame-wide bypass mode, latched when a frame is started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            bypass_r <= bypass;
        end
    end

    // Value written to the data register in PERMUTE.
    always_comb begin
        next_data_s = perm_s;
        if (bypass_r) begin
            next_data_s = data_r;
        end else begin
            next_data_s = perm_s;
        end
    end
`else
    assign next_data_s = perm_s;
`endif

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            data_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= LOAD;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        data_r     <= bus.in_data;
                        in_ready_r <= 1'b0;
                        state_r    <= PERMUTE;
                    end
                end
                PERMUTE: begin
                    data_r      <= next_data_s;
                    out_valid_r <= 1'b1;
                    state_r     <= EMIT;
                end
                EMIT: begin
                    // data_r and out_valid_r hold until the sink takes the line
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (cnt_r == CNT_W'(LINES - 1)) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            cnt_r      <= cnt_r + 1'b1;
                            in_ready_r <= 1'b1;
                            state_r    <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_inv_permutation_stream.sv
// Directed scoreboard bench: expected lines queued at input acceptance, checked at output handshake.
module tb_inv_permutation_stream;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef INV_PERM_BYPASS_EN
    logic bypass;
`endif

    inv_permutation_stream_if bus ();

    inv_permutation_stream dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
`ifdef INV_PERM_BYPASS_EN
        .bypass (bypass),
`endif
        .bus    (bus),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic [24:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder: out[x+5y] = in[((x+3y)%5) + 5x]
    function automatic logic [24:0] fwd(input logic [24:0] p);
        logic [24:0] r;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[x + 5 * y] = p[((x + 3 * y) % 5) + 5 * x];
        return r;
    endfunction

    // Output-side scoreboard check, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            chk("sb_depth", sb.size(), 1);
            if (sb.size() != 0) chk("out_data", bus.out_data, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", bus.in_ready, 1);
    endtask

    task automatic run_line(input logic [24:0] enc, input logic [24:0] exp, input bit bp);
        bit          got;
        logic [24:0] held;
        got = 1'b0;
        bus.in_data  = enc;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        chk("in_accept", got, 1);
        if (got) begin
            sb.push_back(exp);
            step();
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            chk("lat1_out_valid", bus.out_valid, 0);
            if (bp) bus.out_ready = 1'b0;
            step();
            chk("lat2_out_valid", bus.out_valid, 1);
            chk("emit_done", done, 0);
            if (bp) begin
                held = bus.out_data;
                repeat (10) begin
                    step();
                    chk("bp_out_valid", bus.out_valid, 1);
                    chk("bp_out_data", bus.out_data, held);
                    chk("bp_in_ready", bus.in_ready, 0);
                end
                bus.out_ready = 1'b1;
            end
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic finish_frame();
        step();
        chk("end_done", done, 1);
        chk("end_busy", busy, 1);
        step();
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] orig;
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
`ifdef INV_PERM_BYPASS_EN
        bypass        = 1'b0;
`endif
        #1;
        check_idle_outputs("reset");
        repeat (2) step();
        rst = 1'b0;
        step();
        check_idle_outputs("post_reset");

        // Frame 1: single-bit vectors then random round trip, 64 lines total
        start_frame();
        run_line(25'h0000002, 25'h0000040, 1'b0);
        run_line(25'h0000020, 25'h0000008, 1'b0);
        run_line(25'h0000001, 25'h0000001, 1'b0);
        for (int n = 3; n < 64; n++) begin
            orig = 25'($urandom());
            run_line(fwd(orig), orig, 1'b0);
        end
        finish_frame();

        // 65th line must not be accepted while idle
        bus.in_data  = 25'h0155555;
        bus.in_valid = 1'b1;
        repeat (5) begin
            step();
            chk("idle_in_ready", bus.in_ready, 0);
            chk("idle_out_valid", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;

        // Frame 2: aborted by reset after line 20
        start_frame();
        for (int n = 0; n < 20; n++) begin
            orig = 25'($urandom());
            run_line(fwd(orig), orig, 1'b0);
        end
        step();
        chk("sb_empty_pre_rst", sb.size(), 0);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        step();
        rst = 1'b0;
        step();
        check_idle_outputs("mid_rst_rel");

        // Frame 3: full frame with backpressure on line 5
        start_frame();
        for (int n = 0; n < 64; n++) begin
            orig = 25'($urandom());
            run_line(fwd(orig), orig, n == 5);
        end
        finish_frame();

`ifdef INV_PERM_BYPASS_EN
        // Bypass frame: lines pass unaltered with the same latency
        bypass = 1'b1;
        start_frame();
        bypass = 1'b0;
        run_line(25'h1ABCDEF, 25'h1ABCDEF, 1'b0);
        orig = 25'($urandom());
        run_line(orig, orig, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        chk("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
